mem_store_unit: RTL and testbench

MEM_STORE_UNIT -- requirements
Module: mem_store_unit

---
 rtl/mem_store_unit.sv | 145 ++++++++++++++
 tb/tb_mem_store_unit.sv | 289 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_store_unit.sv
// Store unit: turns a MEM-stage store into a single aligned 32-bit memory
// write with byte enables, waits for the memory to acknowledge it, and
// reports completion, a misaligned or reserved request, or a timeout.
module mem_store_unit #(
  parameter int WordSize      = 32,
  parameter int TimeoutCycles = 15
) (
  input  logic                clk,
  input  logic                rstn,
  input  logic                st_valid,
  input  logic [1:0]          st_size,
  input  logic [WordSize-1:0] st_addr,
  input  logic [WordSize-1:0] st_data,
  output logic                st_busy,
  output logic                st_done,
  output logic                st_err,
  output logic                mem_req,
  output logic [WordSize-1:0] mem_addr,
  output logic [WordSize-1:0] mem_wdata,
  output logic [3:0]          mem_be,
  input  logic                mem_ack
);

  typedef enum logic {S_IDLE, S_WAIT} state_t;

  // Last WAIT count value before the memory is considered unresponsive.
  localparam logic [7:0] TO_LAST = 8'(TimeoutCycles - 1);

  state_t                state_q, state_d;
  logic [7:0]            cnt_q, cnt_d;
  logic                  req_q, req_d;
  logic [WordSize-1:0]   addr_q, addr_d;
  logic [WordSize-1:0]   wdata_q, wdata_d;
  logic [3:0]            be_q, be_d;
  logic                  done_q, done_d;
  logic                  err_q, err_d;

  logic                  legal;
  logic [WordSize-1:0]   lane_wdata;
  logic [3:0]            lane_be;

  // Lane placement and legality check of the incoming store.
  always_comb begin
    legal      = 1'b0;
    lane_wdata = st_data;
    lane_be    = 4'b0000;
    case (st_size)
      2'd0: begin
        legal      = 1'b1;
        lane_wdata = {4{st_data[7:0]}};
        lane_be    = 4'b0001 << st_addr[1:0];
      end
      2'd1: begin
        legal      = ~st_addr[0];
        lane_wdata = {2{st_data[15:0]}};
        lane_be    = st_addr[1] ? 4'b1100 : 4'b0011;
      end
      2'd2: begin
        legal      = (st_addr[1:0] == 2'b00);
        lane_wdata = st_data;
        lane_be    = 4'b1111;
      end
      default: begin
        legal      = 1'b0;
        lane_wdata = st_data;
        lane_be    = 4'b0000;
      end
    endcase
  end

  // Next-state and registered-output logic; request fields hold during WAIT.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    req_d   = req_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    be_d    = be_q;
    done_d  = 1'b0;
    err_d   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (st_valid) begin
          if (legal) begin
            addr_d  = {st_addr[WordSize-1:2], 2'b00};
            wdata_d = lane_wdata;
            be_d    = lane_be;
            req_d   = 1'b1;
            cnt_d   = 8'd0;
            state_d = S_WAIT;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      S_WAIT: begin
        // An acknowledge on the expiry edge still counts as success.
        if (mem_ack) begin
          req_d   = 1'b0;
          done_d  = 1'b1;
          state_d = S_IDLE;
        end else if (cnt_q == TO_LAST) begin
          req_d   = 1'b0;
          err_d   = 1'b1;
          state_d = S_IDLE;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and output registers; reset discards any store in flight.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= S_IDLE;
      cnt_q   <= 8'd0;
      req_q   <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      be_q    <= 4'b0000;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      req_q   <= req_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      be_q    <= be_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  assign st_busy   = (state_q == S_WAIT);
  assign st_done   = done_q;
  assign st_err    = err_q;
  assign mem_req   = req_q;
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign mem_be    = be_q;

endmodule

// File: tb/tb_mem_store_unit.sv
// Directed bench for mem_store_unit (built with a 4-cycle timeout).
module tb_mem_store_unit;

  logic        clk = 1'b0;
  logic        rstn;
  logic        st_valid;
  logic [1:0]  st_size;
  logic [31:0] st_addr;
  logic [31:0] st_data;
  logic        st_busy, st_done, st_err, mem_req;
  logic [31:0] mem_addr, mem_wdata;
  logic [3:0]  mem_be;
  logic        mem_ack;

  int checks = 0;
  int errors = 0;

  mem_store_unit #(.WordSize(32), .TimeoutCycles(4)) dut (
    .clk(clk), .rstn(rstn),
    .st_valid(st_valid), .st_size(st_size), .st_addr(st_addr), .st_data(st_data),
    .st_busy(st_busy), .st_done(st_done), .st_err(st_err),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_be(mem_be),
    .mem_ack(mem_ack)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rstn = 1'b0; st_valid = 1'b0; st_size = 2'd0; st_addr = '0; st_data = '0; mem_ack = 1'b0;
    tick(); tick();
    checks++;
    if ({st_busy, st_done, st_err, mem_req, mem_addr, mem_wdata, mem_be} !== 72'd0) begin
      errors++;
      $display("FAIL reset_outputs: busy=%b done=%b err=%b req=%b addr=%h wdata=%h be=%b, expected all zero",
               st_busy, st_done, st_err, mem_req, mem_addr, mem_wdata, mem_be);
    end
    rstn = 1'b1;
    tick();
  endtask

  task automatic test_store_byte();
    st_valid = 1'b1; st_size = 2'd0; st_addr = 32'h0000_1003; st_data = 32'hAABB_CC5A;
    #1;
    checks++;
    if (st_busy !== 1'b0) begin errors++; $display("FAIL sb_accept_busy: got %b expected 0", st_busy); end
    tick();
    st_valid = 1'b0;
    checks++;
    if ({mem_req, st_busy, mem_addr, mem_wdata, mem_be} !== {1'b1, 1'b1, 32'h0000_1000, 32'h5A5A_5A5A, 4'b1000}) begin
      errors++;
      $display("FAIL sb_request: req=%b busy=%b addr=%h wdata=%h be=%b expected 1 1 00001000 5a5a5a5a 1000",
               mem_req, st_busy, mem_addr, mem_wdata, mem_be);
    end
    mem_ack = 1'b1;
    tick();
    mem_ack = 1'b0;
    checks++;
    if ({mem_req, st_busy, st_done, st_err} !== 4'b0010) begin
      errors++;
      $display("FAIL sb_complete: req/busy/done/err=%b expected 0010", {mem_req, st_busy, st_done, st_err});
    end
    tick();
    checks++;
    if (st_done !== 1'b0) begin errors++; $display("FAIL sb_done_pulse: got %b expected 0", st_done); end
  endtask

  task automatic test_byte_lanes();
    logic [3:0] exp_be [4] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000};
    mem_ack = 1'b1;
    for (int a = 0; a < 4; a++) begin
      st_valid = 1'b1; st_size = 2'd0; st_addr = 32'h0000_0010 + a; st_data = 32'h0000_0077;
      tick();
      st_valid = 1'b0;
      checks++;
      if ({mem_be, mem_wdata, mem_addr} !== {exp_be[a], 32'h7777_7777, 32'h0000_0010}) begin
        errors++;
        $display("FAIL sb_lane%0d: be=%b wdata=%h addr=%h expected %b 77777777 00000010",
                 a, mem_be, mem_wdata, mem_addr, exp_be[a]);
      end
      tick();
    end
    st_valid = 1'b1; st_size = 2'd1; st_addr = 32'h0000_0020; st_data = 32'hCAFE_1234;
    tick();
    st_valid = 1'b0;
    checks++;
    if ({mem_be, mem_wdata} !== {4'b0011, 32'h1234_1234}) begin
      errors++;
      $display("FAIL sh_low: be=%b wdata=%h expected 0011 12341234", mem_be, mem_wdata);
    end
    tick();
    mem_ack = 1'b0;
    tick();
  endtask

  task automatic test_store_half_wait();
    int bc = 0;
    int dc = 0;
    int ec = 0;
    st_valid = 1'b1; st_size = 2'd1; st_addr = 32'h0000_2002; st_data = 32'h1234_BEEF;
    tick();
    st_valid = 1'b0;
    checks++;
    if ({mem_req, mem_addr, mem_wdata, mem_be} !== {1'b1, 32'h0000_2000, 32'hBEEF_BEEF, 4'b1100}) begin
      errors++;
      $display("FAIL sh_request: req=%b addr=%h wdata=%h be=%b expected 1 00002000 beefbeef 1100",
               mem_req, mem_addr, mem_wdata, mem_be);
    end
    for (int i = 0; i < 8; i++) begin
      if (st_busy) bc++;
      if (st_done) dc++;
      if (st_err) ec++;
      if (st_busy && (mem_wdata !== 32'hBEEF_BEEF || mem_req !== 1'b1)) begin
        errors++;
        $display("FAIL sh_stable: req=%b wdata=%h expected 1 beefbeef", mem_req, mem_wdata);
      end
      mem_ack = (bc == 3 && st_busy) ? 1'b1 : 1'b0;
      tick();
    end
    mem_ack = 1'b0;
    checks++;
    if ({bc, dc, ec} !== {32'd3, 32'd1, 32'd0}) begin
      errors++;
      $display("FAIL sh_counts: busy=%0d done=%0d err=%0d expected 3 1 0", bc, dc, ec);
    end
  endtask

  task automatic test_illegal();
    logic [1:0]  sz [3] = '{2'd2, 2'd3, 2'd1};
    logic [31:0] ad [3] = '{32'h0000_3001, 32'h0000_3000, 32'h0000_3001};
    for (int k = 0; k < 3; k++) begin
      st_valid = 1'b1; st_size = sz[k]; st_addr = ad[k]; st_data = 32'hDEAD_BEEF;
      tick();
      st_valid = 1'b0;
      checks++;
      if ({mem_req, st_busy, st_err, st_done} !== 4'b0010) begin
        errors++;
        $display("FAIL illegal%0d: req/busy/err/done=%b expected 0010", k, {mem_req, st_busy, st_err, st_done});
      end
      tick();
      checks++;
      if ({st_err, st_busy} !== 2'b00) begin
        errors++;
        $display("FAIL illegal%0d_pulse: err/busy=%b expected 00", k, {st_err, st_busy});
      end
    end
  endtask

  task automatic test_timeout();
    int bc = 0;
    st_valid = 1'b1; st_size = 2'd2; st_addr = 32'h0000_6000; st_data = 32'h0000_0001;
    tick();
    st_valid = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (!st_busy) break;
      bc++;
      tick();
    end
    checks++;
    if ({bc, mem_req, st_err, st_done} !== {32'd4, 3'b010}) begin
      errors++;
      $display("FAIL timeout: wait_cycles=%0d req=%b err=%b done=%b expected 4 0 1 0", bc, mem_req, st_err, st_done);
    end
    tick();
    checks++;
    if ({st_err, st_busy} !== 2'b00) begin
      errors++;
      $display("FAIL timeout_pulse: err/busy=%b expected 00", {st_err, st_busy});
    end
    // acknowledge arriving on the expiry edge
    st_valid = 1'b1;
    tick();
    st_valid = 1'b0;
    tick(); tick(); tick();
    checks++;
    if ({st_busy, mem_req} !== 2'b11) begin
      errors++;
      $display("FAIL ack_expiry_wait: busy/req=%b expected 11", {st_busy, mem_req});
    end
    mem_ack = 1'b1;
    tick();
    mem_ack = 1'b0;
    checks++;
    if ({st_done, st_err, mem_req, st_busy} !== 4'b1000) begin
      errors++;
      $display("FAIL ack_expiry: done/err/req/busy=%b expected 1000", {st_done, st_err, mem_req, st_busy});
    end
    tick();
  endtask

  task automatic test_back_to_back();
    mem_ack = 1'b1;
    st_valid = 1'b1; st_size = 2'd2; st_addr = 32'h0000_4000; st_data = 32'h1111_1111;
    tick();
    checks++;
    if ({mem_req, st_busy, mem_wdata} !== {2'b11, 32'h1111_1111}) begin
      errors++;
      $display("FAIL b2b_first: req=%b busy=%b wdata=%h expected 1 1 11111111", mem_req, st_busy, mem_wdata);
    end
    st_addr = 32'h0000_4004; st_data = 32'h2222_2222;
    tick();
    checks++;
    if ({mem_req, st_busy, st_done} !== 3'b001) begin
      errors++;
      $display("FAIL b2b_gap: req/busy/done=%b expected 001", {mem_req, st_busy, st_done});
    end
    tick();
    st_valid = 1'b0;
    checks++;
    if ({mem_req, mem_addr, mem_wdata} !== {1'b1, 32'h0000_4004, 32'h2222_2222}) begin
      errors++;
      $display("FAIL b2b_second: req=%b addr=%h wdata=%h expected 1 00004004 22222222", mem_req, mem_addr, mem_wdata);
    end
    tick();
    checks++;
    if ({mem_req, st_done} !== 2'b01) begin
      errors++;
      $display("FAIL b2b_done: req/done=%b expected 01", {mem_req, st_done});
    end
    mem_ack = 1'b0;
    tick();
  endtask

  task automatic test_reset_in_wait();
    int bad = 0;
    st_valid = 1'b1; st_size = 2'd2; st_addr = 32'h0000_7000; st_data = 32'h0BAD_F00D;
    tick();
    st_valid = 1'b0;
    tick();
    #2 rstn = 1'b0;
    #1;
    checks++;
    if ({mem_req, st_busy} !== 2'b00) begin
      errors++;
      $display("FAIL rst_wait_drop: req/busy=%b expected 00", {mem_req, st_busy});
    end
    tick(); tick();
    rstn = 1'b1;
    mem_ack = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      if (st_done || st_err || mem_req) bad++;
    end
    mem_ack = 1'b0;
    checks++;
    if (bad !== 0) begin
      errors++;
      $display("FAIL rst_wait_discard: %0d cycles with done/err/req, expected 0", bad);
    end
    rstn = 1'b0;
    tick();
    rstn = 1'b1;
    st_valid = 1'b1; st_size = 2'd0; st_addr = 32'h0000_5001; st_data = 32'h0000_00C3;
    tick();
    st_valid = 1'b0;
    checks++;
    if ({mem_req, mem_addr, mem_wdata, mem_be} !== {1'b1, 32'h0000_5000, 32'hC3C3_C3C3, 4'b0010}) begin
      errors++;
      $display("FAIL rst_next_store: req=%b addr=%h wdata=%h be=%b expected 1 00005000 c3c3c3c3 0010",
               mem_req, mem_addr, mem_wdata, mem_be);
    end
    mem_ack = 1'b1;
    tick();
    mem_ack = 1'b0;
    checks++;
    if ({st_done, st_err, mem_req} !== 3'b100) begin
      errors++;
      $display("FAIL rst_next_done: done/err/req=%b expected 100", {st_done, st_err, mem_req});
    end
  endtask

  initial begin
    test_reset();
    test_store_byte();
    test_byte_lanes();
    test_store_half_wait();
    test_illegal();
    test_timeout();
    test_back_to_back();
    test_reset_in_wait();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
